// File: rtl/dpcm_mc_ord_if.sv
// Stream interface for dpcm_mc_ord: tagged raw-sample input side and
// residual output side, each with valid/ready flow control.
// master = upstream/downstream environment, slave = the encoder.
interface dpcm_mc_ord_if #(
    parameter int DATA_WIDTH = 9,
    parameter int CH_WIDTH   = 2
) ();
    logic [1:0]            order_i;
    logic                  sof_i;
    logic [DATA_WIDTH-1:0] raw_data_i;
    logic [CH_WIDTH-1:0]   raw_ch_i;
    logic                  raw_data_vld_i;
    logic                  raw_data_rdy_o;
    logic [DATA_WIDTH-1:0] dpcm_data_o;
    logic [CH_WIDTH-1:0]   dpcm_ch_o;
    logic                  dpcm_raw_o;
    logic                  dpcm_data_vld_o;
    logic                  dpcm_data_rdy_i;

    modport master (
        output order_i, sof_i, raw_data_i, raw_ch_i, raw_data_vld_i, dpcm_data_rdy_i,
        input  raw_data_rdy_o, dpcm_data_o, dpcm_ch_o, dpcm_raw_o, dpcm_data_vld_o
    );

    modport slave (
        input  order_i, sof_i, raw_data_i, raw_ch_i, raw_data_vld_i, dpcm_data_rdy_i,
        output raw_data_rdy_o, dpcm_data_o, dpcm_ch_o, dpcm_raw_o, dpcm_data_vld_o
    );
endinterface

// File: rtl/dpcm_mc_ord.sv
// dpcm_mc_ord: multi-channel DPCM encoder with per-beat order 0/1/2,
// per-channel history, frame-start warm-up and a single output register.
// Optional feature macro: DPCM_MC_SAT_EN (clamp residuals instead of wrapping).
module dpcm_mc_ord #(
    parameter int DATA_WIDTH = 9,
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = 2,
    parameter int OFFSET     = 256
) (
    input logic          clk_i,
    input logic          reset_n_i,
    dpcm_mc_ord_if.slave bus
);
    // Residual needs headroom for x - 2*h1 + h2 + OFFSET
    localparam int RW = DATA_WIDTH + 3;
    localparam logic signed [RW-1:0] OFFSET_S = RW'(OFFSET);
`ifdef DPCM_MC_SAT_EN
    localparam logic signed [RW-1:0] MAX_S = RW'((1 << DATA_WIDTH) - 1);
`endif

    // Map the wide signed residual onto the output width
    function automatic logic [DATA_WIDTH-1:0] fit_residual(input logic signed [RW-1:0] r);
`ifdef DPCM_MC_SAT_EN
        if (r < 0)
            return '0;
        else if (r > MAX_S)
            return '1;
        else
            return r[DATA_WIDTH-1:0];
`else
        return r[DATA_WIDTH-1:0];
`endif
    endfunction

    logic [DATA_WIDTH-1:0] h1_q  [NUM_CH];
    logic [DATA_WIDTH-1:0] h1_d  [NUM_CH];
    logic [DATA_WIDTH-1:0] h2_q  [NUM_CH];
    logic [DATA_WIDTH-1:0] h2_d  [NUM_CH];
    logic [1:0]            cnt_q [NUM_CH];
    logic [1:0]            cnt_d [NUM_CH];

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic                  raw_q, raw_d;
    logic                  vld_q, vld_d;

    logic                  rdy;
    logic                  accept;
    logic                  ch_ok;
    logic [DATA_WIDTH-1:0] h1_sel, h2_sel;
    logic [1:0]            cnt_sel, cnt_eff, ord;
    logic signed [RW-1:0]  x_s, h1_s, h1x2_s, h2_s, res_s;
    logic [DATA_WIDTH-1:0] out_sel;
    logic                  raw_sel;

    // The output slot is free when empty or being drained this cycle
    assign rdy    = !vld_q || bus.dpcm_data_rdy_i;
    assign accept = bus.raw_data_vld_i && rdy;

    assign bus.raw_data_rdy_o  = rdy;
    assign bus.dpcm_data_o     = data_q;
    assign bus.dpcm_ch_o       = ch_q;
    assign bus.dpcm_raw_o      = raw_q;
    assign bus.dpcm_data_vld_o = vld_q;

    // Select the addressed channel's history and form the output value
    always_comb begin
        ch_ok   = 1'b0;
        h1_sel  = '0;
        h2_sel  = '0;
        cnt_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.raw_ch_i == CH_WIDTH'(c)) begin
                ch_ok   = 1'b1;
                h1_sel  = h1_q[c];
                h2_sel  = h2_q[c];
                cnt_sel = cnt_q[c];
            end
        end
        // A frame start makes this beat the first of its channel
        cnt_eff = bus.sof_i ? 2'd0 : cnt_sel;
        ord     = bus.order_i[1] ? 2'd2 : bus.order_i;
        x_s     = $signed({3'b000, bus.raw_data_i});
        h1_s    = $signed({3'b000, h1_sel});
        h1x2_s  = $signed({2'b00, h1_sel, 1'b0});
        h2_s    = $signed({3'b000, h2_sel});
        case (ord)
            2'd1:    res_s = x_s - h1_s + OFFSET_S;
            2'd2:    res_s = x_s - h1x2_s + h2_s + OFFSET_S;
            default: res_s = x_s;
        endcase
        if (cnt_eff < ord) begin
            out_sel = bus.raw_data_i;
            raw_sel = 1'b1;
        end else if (ord == 2'd0) begin
            out_sel = bus.raw_data_i;
            raw_sel = 1'b0;
        end else begin
            out_sel = fit_residual(res_s);
            raw_sel = 1'b0;
        end
    end

    // Next state for history, warm-up counters and the output register
    always_comb begin
        h1_d   = h1_q;
        h2_d   = h2_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        ch_d   = ch_q;
        raw_d  = raw_q;
        vld_d  = vld_q;
        if (vld_q && bus.dpcm_data_rdy_i)
            vld_d = 1'b0;
        if (accept) begin
            if (bus.sof_i) begin
                for (int c = 0; c < NUM_CH; c++)
                    cnt_d[c] = 2'd0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.raw_ch_i == CH_WIDTH'(c)) begin
                    h2_d[c]  = h1_q[c];
                    h1_d[c]  = bus.raw_data_i;
                    cnt_d[c] = (cnt_eff == 2'd2) ? 2'd2 : cnt_eff + 2'd1;
                end
            end
            // Out-of-range channels are swallowed without producing output
            if (ch_ok) begin
                data_d = out_sel;
                ch_d   = bus.raw_ch_i;
                raw_d  = raw_sel;
                vld_d  = 1'b1;
            end
        end
    end

    // State registers; reset clears pending output and all history
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                h1_q[c]  <= '0;
                h2_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
            data_q <= '0;
            ch_q   <= '0;
            raw_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            h1_q   <= h1_d;
            h2_q   <= h2_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            ch_q   <= ch_d;
            raw_q  <= raw_d;
            vld_q  <= vld_d;
        end
    end
endmodule
